// File: rtl/wb_loopback_pkg.sv
// Shared types and helpers for the Wishbone loopback bring-up block.
package wb_loopback_pkg;

  // Master sequencer: idle after reset, strobe a request, then a fixed idle gap.
  typedef enum logic [1:0] {
    M_IDLE,
    M_REQ,
    M_GAP
  } mst_state_e;

  // Slave responder: idle, count wait states, pulse ack, hold until strobe drops.
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_HOLD
  } slv_state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= max_val) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/wb_loopback_slave_resp.sv
// Wishbone classic slave responder: acks each strobe once after WAIT_STATES cycles.
module wb_loopback_slave_resp
  import wb_loopback_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cyc_i,
  input  logic stb_i,
  output logic ack_o
);

  localparam int WW = cnt_width(WAIT_STATES);
  // Counter is loaded one short so the final WAIT edge is the one that reaches zero.
  localparam logic [WW-1:0] WLOAD = (WAIT_STATES > 0) ? WW'(WAIT_STATES - 1) : '0;

  slv_state_e    state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          ack_q, ack_d;
  logic          req;

  assign req = cyc_i & stb_i;

  // Next-state logic; ack is raised only on the transition into ACK.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WLOAD;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (wcnt_q == '0) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      // A strobe that already fell during the ack cycle skips HOLD so it is not missed.
      S_ACK:   state_d = req ? S_HOLD : S_IDLE;
      S_HOLD:  if (!req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter and ack register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= ack_d;
    end
  end

  // Gate with the live strobe so ack never appears outside an active cycle.
  assign ack_o = ack_q & cyc_i & stb_i;

endmodule

// File: rtl/wb_loopback_core.sv
// Wishbone loopback bring-up block: free-running master plus wait-state slave.
module wb_loopback_core
  import wb_loopback_pkg::*;
#(
  parameter int GAP_CYCLES  = 4,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             cyc_o,
  output logic             stb_o,
  input  logic             ack_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  output logic             ack_o,
  output logic [CNT_W-1:0] txn_count_o,
  output logic             err_o
);

  localparam int TW = cnt_width(TIMEOUT - 1);
  localparam int GW = cnt_width(GAP_CYCLES - 1);
  // Timeout counter starts at 0 on REQ entry; abort when it has seen TIMEOUT edges.
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  mst_state_e       state_q, state_d;
  logic             req_q, req_d;
  logic [TW-1:0]    to_q, to_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Master sequencing; ack is checked before timeout so a coincident ack wins.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    to_d    = to_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      M_IDLE: begin
        state_d = M_REQ;
        req_d   = 1'b1;
        to_d    = '0;
      end
      M_REQ: begin
        if (ack_i) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = M_GAP;
          req_d   = 1'b0;
          gap_d   = GAP_LOAD;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = M_GAP;
          req_d   = 1'b0;
          gap_d   = GAP_LOAD;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      M_GAP: begin
        if (gap_q == '0) begin
          state_d = M_REQ;
          req_d   = 1'b1;
          to_d    = '0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = M_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Master state, registered strobe, timeout/gap counters, txn count and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= M_IDLE;
      req_q   <= 1'b0;
      to_q    <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // cyc and stb share one flop so they always rise and fall together.
  assign cyc_o       = req_q;
  assign stb_o       = req_q;
  assign txn_count_o = cnt_q;
  assign err_o       = err_q;

  wb_loopback_slave_resp #(
    .WAIT_STATES (WAIT_STATES)
  ) u_slave (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cyc_i (cyc_i),
    .stb_i (stb_i),
    .ack_o (ack_o)
  );

endmodule

// File: tb/tb_wb_loopback_core.sv
// Bench: two configurations driven in lockstep against a behavioural model.
module tb_wb_loopback_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i, loop, ack_drv, cyc_drv, stb_drv;
  logic [1:0] cyc_o_v, stb_o_v, ack_o_v, err_v, cyc_i_v, stb_i_v, ack_i_v;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  assign cyc_i_v = loop ? cyc_o_v : {2{cyc_drv}};
  assign stb_i_v = loop ? stb_o_v : {2{stb_drv}};
  assign ack_i_v = loop ? ack_o_v : {2{ack_drv}};

  wb_loopback_core u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .cyc_o(cyc_o_v[0]), .stb_o(stb_o_v[0]),
    .ack_i(ack_i_v[0]), .cyc_i(cyc_i_v[0]), .stb_i(stb_i_v[0]), .ack_o(ack_o_v[0]),
    .txn_count_o(cnt0), .err_o(err_v[0])
  );

  wb_loopback_core #(.GAP_CYCLES(1), .WAIT_STATES(0), .TIMEOUT(4), .CNT_W(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .cyc_o(cyc_o_v[1]), .stb_o(stb_o_v[1]),
    .ack_i(ack_i_v[1]), .cyc_i(cyc_i_v[1]), .stb_i(stb_i_v[1]), .ack_o(ack_o_v[1]),
    .txn_count_o(cnt1), .err_o(err_v[1])
  );

  int p_ws[2]  = '{1, 0};
  int p_gap[2] = '{4, 1};
  int p_to[2]  = '{16, 4};
  int p_cw[2]  = '{16, 2};

  // Reference model: strobe active flag, edges since strobe rose, gap cycles left,
  // total completed transactions, sticky error, and consecutive sampled slave strobe edges.
  bit m_act[2];
  bit m_err[2];
  int m_age[2];
  int m_gap[2];
  int m_cnt[2];
  int s_run[2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock: apply inputs, compare at negedge, advance model at posedge.
  task automatic step(input bit r, input bit a, input bit c, input bit s);
    bit cin[2], sin[2], ain[2], aexp[2];
    logic [31:0] cnt_obs;
    rst_i = r; ack_drv = a; cyc_drv = c; stb_drv = s;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cin[k]  = loop ? m_act[k] : c;
      sin[k]  = loop ? m_act[k] : s;
      aexp[k] = (s_run[k] == p_ws[k] + 1) && cin[k] && sin[k];
      ain[k]  = loop ? aexp[k] : a;
      cnt_obs = (k == 0) ? 32'(cnt0) : 32'(cnt1);
      chk($sformatf("stb_o%0d", k), 32'(stb_o_v[k]), 32'(m_act[k]));
      chk($sformatf("cyc_o%0d", k), 32'(cyc_o_v[k]), 32'(m_act[k]));
      chk($sformatf("ack_o%0d", k), 32'(ack_o_v[k]), 32'(aexp[k]));
      chk($sformatf("err_o%0d", k), 32'(err_v[k]), 32'(m_err[k]));
      chk($sformatf("cnt%0d", k), cnt_obs, 32'(m_cnt[k] % (1 << p_cw[k])));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_act[k] = 0; m_err[k] = 0; m_age[k] = 0; m_gap[k] = 0; m_cnt[k] = 0; s_run[k] = 0;
      end else begin
        if (cin[k] && sin[k]) s_run[k] = (s_run[k] < 1000) ? s_run[k] + 1 : s_run[k];
        else s_run[k] = 0;
        if (!m_act[k]) begin
          if (m_gap[k] > 1) m_gap[k]--;
          else begin m_act[k] = 1; m_age[k] = 0; m_gap[k] = 0; end
        end else if (ain[k]) begin
          m_cnt[k]++; m_act[k] = 0; m_gap[k] = p_gap[k];
        end else begin
          m_age[k]++;
          if (m_age[k] == p_to[k]) begin m_err[k] = 1; m_act[k] = 0; m_gap[k] = p_gap[k]; end
        end
      end
    end
    #1;
  endtask

  // Waveform-shape monitor: first strobe high length, first rise-to-rise period,
  // ack pulse count, and the sequence of count values for the 2-bit instance.
  bit         mon_clr;
  int         cyc_no = 0;
  int         last_rise[2], hi_len[2], period[2], ack_pulses[2];
  logic [1:0] prev_stb, prev_ack, prev_cnt1;
  int         seq1[$];

  always @(negedge clk) begin
    cyc_no++;
    for (int k = 0; k < 2; k++) begin
      if (mon_clr) begin
        last_rise[k] = -1; hi_len[k] = 0; period[k] = 0; ack_pulses[k] = 0;
      end else begin
        if (stb_o_v[k] && !prev_stb[k]) begin
          if (last_rise[k] >= 0 && period[k] == 0) period[k] = cyc_no - last_rise[k];
          last_rise[k] = cyc_no;
        end
        if (!stb_o_v[k] && prev_stb[k] && last_rise[k] >= 0 && hi_len[k] == 0)
          hi_len[k] = cyc_no - last_rise[k];
        if (ack_o_v[k] && !prev_ack[k]) ack_pulses[k]++;
      end
      prev_stb[k] = stb_o_v[k];
      prev_ack[k] = ack_o_v[k];
    end
    if (mon_clr) seq1.delete();
    else if (cnt1 != prev_cnt1) seq1.push_back(int'(cnt1));
    prev_cnt1 = cnt1;
  end

  initial begin
    bit sv, cv;
    sv = 0; cv = 0;
    loop = 1'b1; ack_drv = 0; cyc_drv = 0; stb_drv = 0;
    rst_i = 1'b1; mon_clr = 1'b1;
    @(posedge clk); @(negedge clk); @(posedge clk); #1;
    mon_clr = 1'b0;
    chk("rst_stb", 32'(stb_o_v), 32'd0);
    chk("rst_ack", 32'(ack_o_v), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_err", 32'(err_v), 32'd0);

    // Loopback from reset release.
    for (int i = 1; i <= 46; i++) begin
      step(0, 0, 0, 0);
      if (i == 31) chk("cnt1_at31", 32'(cnt1), 32'd2);
    end
    chk("cnt0_at46", 32'(cnt0), 32'd7);
    chk("err_loop", 32'(err_v), 32'd0);
    chk("hi_len0", 32'(hi_len[0]), 32'd3);
    chk("period0", 32'(period[0]), 32'd7);
    chk("hi_len1", 32'(hi_len[1]), 32'd2);
    chk("period1", 32'(period[1]), 32'd3);
    chk("ack_len0", 32'(ack_pulses[0] > 0), 32'd1);
    chk("seq_len", 32'(seq1.size() >= 5), 32'd1);
    begin
      int exp_seq[5] = '{1, 2, 3, 0, 1};
      for (int i = 0; i < 5; i++)
        chk($sformatf("seq%0d", i), 32'((seq1.size() > i) ? seq1[i] : -1), 32'(exp_seq[i]));
    end

    // Timeout: no acks at all.
    loop = 1'b0; mon_clr = 1'b1;
    step(1, 0, 0, 0);
    mon_clr = 1'b0;
    for (int i = 0; i < 45; i++) step(0, 0, 0, 0);
    chk("to_hi0", 32'(hi_len[0]), 32'd16);
    chk("to_period0", 32'(period[0]), 32'd20);
    chk("to_hi1", 32'(hi_len[1]), 32'd4);
    chk("to_period1", 32'(period[1]), 32'd5);
    chk("to_err", 32'(err_v), 32'd3);
    chk("to_cnt0", 32'(cnt0), 32'd0);

    // Reset while the default slave sits in WAIT.
    loop = 1'b1;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("midrst_stb", 32'(stb_o_v[0]), 32'd0);
    chk("midrst_cyc", 32'(cyc_o_v[0]), 32'd0);
    chk("midrst_ack", 32'(ack_o_v[0]), 32'd0);
    chk("midrst_cnt", 32'(cnt0), 32'd0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
    chk("resume_cnt0", 32'(cnt0), 32'd3);
    chk("resume_cnt1", 32'(cnt1), 32'd2);

    // Slave only: long strobe gives one ack; a one-edge strobe gives none.
    loop = 1'b0; mon_clr = 1'b1;
    step(1, 0, 0, 0);
    mon_clr = 1'b0;
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("one_ack0", 32'(ack_pulses[0]), 32'd1);
    chk("one_ack1", 32'(ack_pulses[1]), 32'd1);
    mon_clr = 1'b1;
    step(0, 0, 0, 0);
    mon_clr = 1'b0;
    step(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("drop_ack0", 32'(ack_pulses[0]), 32'd0);
    chk("drop_ack1", 32'(ack_pulses[1]), 32'd0);

    // Random traffic: mode switches, sporadic resets, random acks and strobe runs.
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) loop = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) sv = ~sv;
      cv = ($urandom_range(0, 7) != 0) ? sv : 1'($urandom_range(0, 1));
      step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), cv, sv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
